// File: rtl/pipTypes.sv
// pipTypes: shared pipeline types for the multiply/divide scheduler
package pipTypes;
  typedef enum logic [3:0] {
    OP_NONE,
    OP_ALU,
    OP_MUL,
    OP_MADD,
    OP_DIV,
    OP_MFHI,
    OP_MFLO,
    OP_MTHI,
    OP_MTLO
  } muldiv_op_t;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } muldiv_sched_state_t;
  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 35;
  // Long ops occupy the shared multiplier/divider and end in a HI/LO write
  function automatic logic is_long(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MADD, OP_DIV};
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter with registered last-grant pointer
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);
  logic last_q, last_d;
  assign gnt = (req == 2'b11) ? (last_q ? 2'b01 : 2'b10) : req;
  // pointer moves only when the caller actually accepts the grant
  always_comb begin
    last_d = (adv && |gnt) ? gnt[1] : last_q;
  end
  // last-grant register; slot 1 after reset so slot 0 wins first
  always_ff @(posedge clock or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end
endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: issues long mul/div ops to a shared unit and sequences the HI/LO commit
module muldiv_sched
  import pipTypes::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_WIDTH  = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req_valid,
  input  muldiv_op_t req_op [2],
  input  logic [1:0] req_u,
  output logic [1:0] req_ready,
  input  logic       flush,
  output logic       unit_start,
  output muldiv_op_t unit_op,
  output logic       unit_u,
  output logic       unit_sel,
  output logic       hilo_busy,
  output logic       hilo_wr,
  output logic       done_slot
);
  muldiv_sched_state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic busy_q, busy_d, u_q, u_d, sel_q, sel_d;
  muldiv_op_t op_q, op_d;
  logic [1:0] lng, sht, arb_gnt, hs;
  logic mixed, ok, start;
  // classify requests; a mixed long/short pair always goes to slot 0
  always_comb begin
    lng   = {req_valid[1] & is_long(req_op[1]), req_valid[0] & is_long(req_op[0])};
    sht   = req_valid & ~lng;
    mixed = (lng[0] & sht[1]) | (sht[0] & lng[1]);
    ok    = (state_q == ST_IDLE) && !busy_q && !flush && !reset;
  end
  rr_arb2 u_arb (
    .clock(clock),
    .reset(reset),
    .req  (lng),
    .adv  (start),
    .gnt  (arb_gnt)
  );
  // accept only in IDLE; short ops need no arbitration among themselves
  always_comb begin
    req_ready = !ok ? 2'b00 : mixed ? 2'b01 : (sht | arb_gnt);
    hs        = req_valid & req_ready & lng;
    start     = |hs;
  end
  // next-state: flush wins, otherwise launch, count down, commit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    op_d    = op_q;
    u_d     = u_q;
    sel_d   = sel_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_d = ST_BUSY;
          busy_d  = 1'b1;
          sel_d   = hs[1];
          op_d    = req_op[hs[1]];
          u_d     = req_u[hs[1]];
          cnt_d   = (req_op[hs[1]] == OP_DIV) ? CNT_WIDTH'(DIV_CYCLES) : CNT_WIDTH'(MUL_CYCLES);
        end
        ST_BUSY: begin
          cnt_d   = cnt_q - CNT_WIDTH'(1);
          state_d = (cnt_q == CNT_WIDTH'(2)) ? ST_DONE : ST_BUSY;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end
  // state and latched request registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      op_q    <= OP_NONE;
      u_q     <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      op_q    <= op_d;
      u_q     <= u_d;
      sel_q   <= sel_d;
    end
  end
  // outputs; the commit strobe is dropped if a flush lands in DONE
  always_comb begin
    unit_start = start;
    unit_op    = op_q;
    unit_u     = u_q;
    unit_sel   = sel_q;
    hilo_busy  = busy_q;
    hilo_wr    = (state_q == ST_DONE) && !flush;
    done_slot  = hilo_wr & sel_q;
  end
endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: directed vectors and multi-cycle sequences for muldiv_sched
module tb_muldiv_sched;
  import pipTypes::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_u = 2'b00;
  logic [1:0] req_ready;
  muldiv_op_t req_op [2];
  logic unit_start, unit_u, unit_sel, hilo_busy, hilo_wr, done_slot;
  muldiv_op_t unit_op;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] v;
    muldiv_op_t o0;
    muldiv_op_t o1;
    logic [1:0] rdy;
    logic       st;
  } vec_t;
  vec_t tbl [10];

  muldiv_sched dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_u     (req_u),
    .req_ready (req_ready),
    .flush     (flush),
    .unit_start(unit_start),
    .unit_op   (unit_op),
    .unit_u    (unit_u),
    .unit_sel  (unit_sel),
    .hilo_busy (hilo_busy),
    .hilo_wr   (hilo_wr),
    .done_slot (done_slot)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic go();
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic [1:0] v, input muldiv_op_t o0, input muldiv_op_t o1, input logic [1:0] u);
    req_valid = v;
    req_op[0] = o0;
    req_op[1] = o1;
    req_u     = u;
    #4;
  endtask

  initial begin
    req_op[0] = OP_NONE;
    req_op[1] = OP_NONE;
    tbl[0] = '{2'b00, OP_MUL,  OP_MUL,  2'b00, 1'b0};
    tbl[1] = '{2'b01, OP_MUL,  OP_NONE, 2'b01, 1'b1};
    tbl[2] = '{2'b10, OP_NONE, OP_DIV,  2'b10, 1'b1};
    tbl[3] = '{2'b11, OP_MUL,  OP_DIV,  2'b01, 1'b1};
    tbl[4] = '{2'b01, OP_MFHI, OP_NONE, 2'b01, 1'b0};
    tbl[5] = '{2'b11, OP_MFHI, OP_MFLO, 2'b11, 1'b0};
    tbl[6] = '{2'b11, OP_MTHI, OP_MUL,  2'b01, 1'b0};
    tbl[7] = '{2'b11, OP_MADD, OP_MTLO, 2'b01, 1'b1};
    tbl[8] = '{2'b10, OP_NONE, OP_MFLO, 2'b10, 1'b0};
    tbl[9] = '{2'b00, OP_NONE, OP_NONE, 2'b00, 1'b0};
    #2;
    chk("rst unit_start", unit_start, 0);
    chk("rst unit_sel", unit_sel, 0);
    chk("rst unit_u", unit_u, 0);
    chk("rst hilo_busy", hilo_busy, 0);
    chk("rst hilo_wr", hilo_wr, 0);
    chk("rst done_slot", done_slot, 0);
    chk("rst unit_op", unit_op, OP_NONE);
    chk("rst req_ready", req_ready, 0);
    #10 reset = 1'b0;
    // combinational arbitration in IDLE, valid dropped before every edge
    for (int i = 0; i < 10; i++) begin
      go();
      drv(tbl[i].v, tbl[i].o0, tbl[i].o1, 2'b00);
      chk($sformatf("tbl%0d ready", i), req_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d start", i), unit_start, tbl[i].st);
      req_valid = 2'b00;
    end
    // both slots DIV: slot0 first, slot1 after the DONE bubble
    go(); drv(2'b11, OP_DIV, OP_DIV, 2'b11);
    chk("B0 ready", req_ready, 2'b01);
    chk("B0 start", unit_start, 1);
    for (int k = 1; k <= 35; k++) begin
      go(); drv(2'b11, OP_DIV, OP_DIV, 2'b11);
      chk($sformatf("B%0d ready", k), req_ready, 0);
      chk($sformatf("B%0d hilo_wr", k), hilo_wr, k == 35);
      if (k == 1) begin
        chk("B1 unit_sel", unit_sel, 0);
        chk("B1 unit_op", unit_op, OP_DIV);
        chk("B1 unit_u", unit_u, 1);
        chk("B1 hilo_busy", hilo_busy, 1);
      end
      if (k == 35) chk("B35 done_slot", done_slot, 0);
    end
    go(); drv(2'b11, OP_DIV, OP_DIV, 2'b11);
    chk("B36 ready", req_ready, 2'b10);
    chk("B36 start", unit_start, 1);
    for (int k = 37; k <= 71; k++) begin
      go(); drv(2'b00, OP_NONE, OP_NONE, 2'b00);
      chk($sformatf("B%0d hilo_wr", k), hilo_wr, k == 71);
      if (k == 37) chk("B37 unit_sel", unit_sel, 1);
      if (k == 71) chk("B71 done_slot", done_slot, 1);
    end
    go(); drv(2'b00, OP_NONE, OP_NONE, 2'b00);
    chk("B72 hilo_busy", hilo_busy, 0);
    // single MUL: latency 5, ready held low through DONE
    go(); drv(2'b01, OP_MUL, OP_NONE, 2'b00);
    chk("A0 start", unit_start, 1);
    for (int k = 1; k <= 5; k++) begin
      go(); drv(2'b01, OP_MUL, OP_NONE, 2'b00);
      chk($sformatf("A%0d ready", k), req_ready, 0);
      chk($sformatf("A%0d hilo_wr", k), hilo_wr, k == 5);
      chk($sformatf("A%0d start", k), unit_start, 0);
      if (k == 5) chk("A5 done_slot", done_slot, 0);
    end
    go(); drv(2'b00, OP_NONE, OP_NONE, 2'b00);
    chk("A6 hilo_busy", hilo_busy, 0);
    // MFLO stalls behind a pending MUL
    go(); drv(2'b01, OP_MUL, OP_NONE, 2'b00);
    chk("C0 start", unit_start, 1);
    go(); drv(2'b00, OP_NONE, OP_NONE, 2'b00);
    for (int k = 2; k <= 5; k++) begin
      go(); drv(2'b01, OP_MFLO, OP_NONE, 2'b00);
      chk($sformatf("C%0d ready", k), req_ready, 0);
      chk($sformatf("C%0d hilo_wr", k), hilo_wr, k == 5);
    end
    go(); drv(2'b01, OP_MFLO, OP_NONE, 2'b00);
    chk("C6 ready", req_ready, 2'b01);
    chk("C6 start", unit_start, 0);
    go(); drv(2'b00, OP_NONE, OP_NONE, 2'b00);
    chk("C7 hilo_busy", hilo_busy, 0);
    // flush a DIV when the counter is at 10, then accept a MUL
    go(); drv(2'b01, OP_DIV, OP_NONE, 2'b00);
    chk("D0 start", unit_start, 1);
    for (int k = 1; k <= 25; k++) begin
      go(); drv(2'b00, OP_NONE, OP_NONE, 2'b00);
    end
    chk("D25 hilo_busy", hilo_busy, 1);
    go(); flush = 1'b1; drv(2'b01, OP_MUL, OP_NONE, 2'b00);
    chk("D26 ready", req_ready, 0);
    chk("D26 start", unit_start, 0);
    go(); flush = 1'b0; drv(2'b01, OP_MUL, OP_NONE, 2'b00);
    chk("D27 hilo_busy", hilo_busy, 0);
    chk("D27 ready", req_ready, 2'b01);
    chk("D27 start", unit_start, 1);
    for (int k = 28; k <= 40; k++) begin
      go(); drv(2'b00, OP_NONE, OP_NONE, 2'b00);
      chk($sformatf("D%0d hilo_wr", k), hilo_wr, k == 32);
    end
    // asynchronous reset in the middle of a MADD
    go(); drv(2'b01, OP_MADD, OP_NONE, 2'b01);
    chk("E0 start", unit_start, 1);
    go(); drv(2'b00, OP_NONE, OP_NONE, 2'b00);
    chk("E1 hilo_busy", hilo_busy, 1);
    chk("E1 unit_u", unit_u, 1);
    go(); #1 reset = 1'b1; #1;
    chk("E busy", hilo_busy, 0);
    chk("E hilo_wr", hilo_wr, 0);
    chk("E unit_op", unit_op, OP_NONE);
    chk("E unit_u", unit_u, 0);
    chk("E unit_sel", unit_sel, 0);
    chk("E start", unit_start, 0);
    chk("E done_slot", done_slot, 0);
    go(); go(); reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      go(); #4;
      chk($sformatf("E post%0d hilo_wr", k), hilo_wr, 0);
    end
    // mixed short/long grants slot0 without moving the pointer
    go(); drv(2'b11, OP_MTHI, OP_MUL, 2'b00);
    chk("F0 ready", req_ready, 2'b01);
    chk("F0 start", unit_start, 0);
    go(); drv(2'b11, OP_MUL, OP_MUL, 2'b00);
    chk("F1 ready", req_ready, 2'b01);
    chk("F1 start", unit_start, 1);
    for (int k = 2; k <= 6; k++) begin
      go(); drv(2'b00, OP_NONE, OP_NONE, 2'b00);
    end
    go(); drv(2'b11, OP_MTHI, OP_MUL, 2'b00);
    chk("F7 ready", req_ready, 2'b01);
    chk("F7 start", unit_start, 0);
    go(); drv(2'b10, OP_NONE, OP_MUL, 2'b00);
    chk("F8 ready", req_ready, 2'b10);
    chk("F8 start", unit_start, 1);
    for (int k = 9; k <= 14; k++) begin
      go(); drv(2'b00, OP_NONE, OP_NONE, 2'b00);
      if (k == 13) chk("F13 done_slot", done_slot, 1);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
